// File: rtl/user_cl_aes_stream.sv
// FIFO-to-block-cipher adapter: packs FIFO words into key/data blocks, runs an
// external cipher core through start/done, unpacks results and reports status.
module user_cl_aes_stream #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BLOCK_WIDTH    = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   data_empty,
    output logic                   data_rd,
    input  logic [DATA_WIDTH-1:0]  data_din,
    input  logic                   data_full,
    output logic                   data_wr,
    output logic [DATA_WIDTH-1:0]  data_dout,
    input  logic                   ctrl_empty,
    output logic                   ctrl_rd,
    input  logic [DATA_WIDTH-1:0]  ctrl_din,
    input  logic                   ctrl_full,
    output logic                   ctrl_wr,
    output logic [DATA_WIDTH-1:0]  ctrl_dout,
    output logic                   core_start,
    output logic                   core_decrypt,
    output logic [BLOCK_WIDTH-1:0] core_key,
    output logic [BLOCK_WIDTH-1:0] core_din,
    input  logic                   core_done,
    input  logic [BLOCK_WIDTH-1:0] core_dout
);

    localparam int unsigned WORDS = BLOCK_WIDTH / DATA_WIDTH;
    localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TCW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] OP_LOAD_KEY = 4'h1;
    localparam logic [3:0] OP_RUN      = 4'h2;
    localparam logic [3:0] CODE_OK     = 4'hA;
    localparam logic [3:0] CODE_ERR    = 4'hE;
    localparam logic [3:0] CODE_TMO    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_KEY_FILL, S_DATA_FILL,
        S_CORE_START, S_CORE_WAIT, S_DRAIN, S_STATUS
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic        decrypt;
        logic [15:0] count;
    } cmd_t;

    state_t                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic                   key_valid_q, key_valid_d;
    logic [BLOCK_WIDTH-1:0] key_d, din_d;
    logic [BLOCK_WIDTH-1:0] out_q, out_d;
    logic [WCW-1:0]         word_q, word_d;
    logic [15:0]            blocks_q, blocks_d;
    logic [TCW-1:0]         tmo_q, tmo_d;
    logic [3:0]             code_q, code_d;
    logic                   dec_d;
    logic                   data_rd_c, data_wr_c, ctrl_rd_c, ctrl_wr_c;
    logic                   last_word;
    logic                   unused_ctrl;

    assign last_word   = (word_q == WCW'(WORDS - 1));
    assign unused_ctrl = ^ctrl_din;

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        key_valid_d = key_valid_q;
        key_d       = core_key;
        din_d       = core_din;
        out_d       = out_q;
        word_d      = word_q;
        blocks_d    = blocks_q;
        tmo_d       = tmo_q;
        code_d      = code_q;
        dec_d       = core_decrypt;
        data_rd_c   = 1'b0;
        data_wr_c   = 1'b0;
        ctrl_rd_c   = 1'b0;
        ctrl_wr_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ctrl_rd_c = ~ctrl_empty;
                if (!ctrl_empty) begin
                    cmd_d   = '{opcode: ctrl_din[31:28], decrypt: ctrl_din[16], count: ctrl_din[15:0]};
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                word_d = '0;
                if (cmd_q.opcode == OP_LOAD_KEY) begin
                    state_d = S_KEY_FILL;
                end else if (cmd_q.opcode == OP_RUN && key_valid_q && cmd_q.count != 16'd0) begin
                    dec_d   = cmd_q.decrypt;
                    state_d = S_DATA_FILL;
                end else begin
                    code_d  = (cmd_q.opcode == OP_RUN && key_valid_q) ? CODE_OK : CODE_ERR;
                    state_d = S_STATUS;
                end
            end
            S_KEY_FILL: begin
                data_rd_c = ~data_empty;
                if (!data_empty) begin
                    key_d  = (core_key << DATA_WIDTH) | BLOCK_WIDTH'(data_din);
                    word_d = word_q + WCW'(1);
                    if (last_word) begin
                        word_d      = '0;
                        key_valid_d = 1'b1;
                        code_d      = CODE_OK;
                        state_d     = S_STATUS;
                    end
                end
            end
            S_DATA_FILL: begin
                data_rd_c = ~data_empty;
                if (!data_empty) begin
                    din_d  = (core_din << DATA_WIDTH) | BLOCK_WIDTH'(data_din);
                    word_d = word_q + WCW'(1);
                    if (last_word) begin
                        word_d  = '0;
                        state_d = S_CORE_START;
                    end
                end
            end
            S_CORE_START: begin
                tmo_d   = '0;
                state_d = S_CORE_WAIT;
            end
            S_CORE_WAIT: begin
                if (core_done) begin
                    out_d   = core_dout;
                    state_d = S_DRAIN;
                end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    code_d  = CODE_TMO;
                    state_d = S_STATUS;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            S_DRAIN: begin
                data_wr_c = ~data_full;
                if (!data_full) begin
                    out_d  = out_q << DATA_WIDTH;
                    word_d = word_q + WCW'(1);
                    if (last_word) begin
                        word_d   = '0;
                        blocks_d = blocks_q + 16'd1;
                        if (blocks_q + 16'd1 == cmd_q.count) begin
                            code_d  = CODE_OK;
                            state_d = S_STATUS;
                        end else begin
                            state_d = S_DATA_FILL;
                        end
                    end
                end
            end
            S_STATUS: begin
                ctrl_wr_c = ~ctrl_full;
                if (!ctrl_full) begin
                    blocks_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset_n is an active-high synchronous reset
    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            key_valid_q  <= 1'b0;
            core_key     <= '0;
            core_din     <= '0;
            out_q        <= '0;
            word_q       <= '0;
            blocks_q     <= '0;
            tmo_q        <= '0;
            code_q       <= '0;
            core_decrypt <= 1'b0;
            core_start   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            key_valid_q  <= key_valid_d;
            core_key     <= key_d;
            core_din     <= din_d;
            out_q        <= out_d;
            word_q       <= word_d;
            blocks_q     <= blocks_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            core_decrypt <= dec_d;
            core_start   <= (state_d == S_CORE_START);
        end
    end

    // FIFO-side outputs are combinational and forced low while reset is held
    assign data_rd   = data_rd_c & ~reset_n;
    assign data_wr   = data_wr_c & ~reset_n;
    assign ctrl_rd   = ctrl_rd_c & ~reset_n;
    assign ctrl_wr   = ctrl_wr_c & ~reset_n;
    assign data_dout = (state_q == S_DRAIN && !reset_n) ? out_q[BLOCK_WIDTH-1 -: DATA_WIDTH] : '0;
    assign ctrl_dout = (state_q == S_STATUS && !reset_n) ?
                       DATA_WIDTH'({code_q, 12'b0, blocks_q}) : '0;

endmodule

// File: doc/user_cl_aes_stream.md
# user_cl_aes_stream

Parametrised FIFO-to-block-cipher adapter for the custom-logic (CL) user slot. It accepts commands from the control FIFO and packs DATA_WIDTH-bit words from the input FIFO into BLOCK_WIDTH-bit key or data blocks. It drives an external block-cipher core through a start/done handshake, unpacks each result block into the output FIFO, and reports completion or error status through the control output FIFO. It replaces the fixed 8-bit, single-mode wrapper with multi-block runs, a selectable encrypt/decrypt mode, key retention, timeout, and status reporting.

## Interface
- DATA_WIDTH, 32, FIFO word width; ≥32; must divide BLOCK_WIDTH
- BLOCK_WIDTH, 128, cipher block and key width
- TIMEOUT_CYCLES, 1024, maximum cycles spent in CORE_WAIT per block
- Derived: WORDS = BLOCK_WIDTH/DATA_WIDTH
- clock  in  1  sole clock
- reset_n  in  1  synchronous reset, active-high despite the name
- data_empty  in  1  input FIFO empty; FWFT, so data_din is valid whenever data_empty=0
- data_rd  out  1  input pop; combinational
- data_din  in  DATA_WIDTH  input word
- data_full  in  1  output FIFO full
- data_wr  out  1  output push; combinational
- data_dout  out  DATA_WIDTH  output word
- ctrl_empty  in  1  command FIFO empty; FWFT
- ctrl_rd  out  1  command pop; combinational
- ctrl_din  in  DATA_WIDTH  command word
- ctrl_full  in  1  status FIFO full
- ctrl_wr  out  1  status push; combinational
- ctrl_dout  out  DATA_WIDTH  status word
- core_start  out  1  one-cycle start pulse, registered
- core_decrypt  out  1  mode bit; held for the whole run
- core_key  out  BLOCK_WIDTH  key register
- core_din  out  BLOCK_WIDTH  input block register
- core_done  in  1  one-cycle pulse; core_dout is valid in the same cycle
- core_dout  in  BLOCK_WIDTH  result block

## Operation
- Command fields: opcode = ctrl_din[31:28]; decrypt flag = ctrl_din[16]; block count N = ctrl_din[15:0].
  - 0x1 LOAD_KEY: consumes WORDS words into core_key.
  - 0x2 RUN: processes N blocks.
  - Any other opcode: error.
- Packing: the first word popped fills bits [BLOCK_WIDTH-1 : BLOCK_WIDTH-DATA_WIDTH]. Unpacking emits the MS word first.
- States:
  - IDLE: ctrl_rd = ~ctrl_empty. On a pop, latch the command and go to CMD.
  - CMD:
    - LOAD_KEY → KEY_FILL.
    - RUN with key_valid=0 → STATUS, code 0xE.
    - RUN with N=0 → STATUS, code 0xA, count 0.
    - RUN otherwise → latch core_decrypt and go to DATA_FILL.
    - Bad opcode → STATUS, code 0xE.
  - KEY_FILL / DATA_FILL: data_rd = ~data_empty. Each pop shifts one word into the target register and increments the word counter. After WORDS pops:
    - KEY_FILL → set key_valid and go to STATUS (0xA, count 0).
    - DATA_FILL → go to CORE_START.
  - CORE_START: core_start=1 for exactly one cycle; clear the timeout counter; → CORE_WAIT.
  - CORE_WAIT:
    - On core_done, capture core_dout into the output shift register → DRAIN.
    - If the timeout counter reaches TIMEOUT_CYCLES first → STATUS, code 0xF. key_valid is kept.
  - DRAIN: data_wr = ~data_full, data_dout = top word; each push shifts. After WORDS pushes, increment blocks_done, then:
    - blocks_done == N → STATUS, code 0xA.
    - Otherwise → DATA_FILL.
  - STATUS: ctrl_dout = {code[3:0], 12'b0, blocks_done[15:0]}, zero-extended above bit 31. ctrl_wr = ~ctrl_full. After the push, clear blocks_done and go to IDLE.
- Boundary conditions:
  - core_done outside CORE_WAIT is ignored.
  - data_empty or data_full stalls the FSM in place, with no word lost or duplicated.
  - ctrl_full stalls STATUS.
  - A LOAD_KEY that arrives while key_valid=1 overwrites the key.
  - Data words are never consumed by an errored command.
- Reset:
  - All registers clear: key_valid=0, counters=0, core_key/core_din=0, core_start=0, core_decrypt=0, state=IDLE.
  - All combinational outputs evaluate to 0.
  - Reset mid-run abandons the run with no status word, and the key is lost.

## Timing
- One word moves per cycle in FILL and DRAIN while the FIFOs permit.
- RUN with N=1, FIFOs never stalled, core latency L cycles (done pulse L cycles after start):
  - command pop at cycle 0, CMD at 1, pops at 2–5, core_start at 6
  - data_wr at 7+L through 10+L, ctrl_wr at 11+L
- Each additional block adds WORDS + 1 + L + WORDS cycles. There is no overlap between blocks.
- core_key and core_din are stable from core_start until core_done.

## Test plan
- Reset, then LOAD_KEY with key words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c → core_key = 0x2b7e151628aed2a6abf7158809cf4f3c; status 0xA0000000.
- RUN N=1 encrypt with data 0x3243f6a8_885a308d_313198a2_e0370734 and a core model → core_start pulses once; output words 0x3925841d, 0x02dc09fb, 0xdc118597, 0x196a0b32; status 0xA0000001.
- RUN N=3 with decrypt flag set, with data_empty and data_full toggled randomly → 12 words out in order, core_decrypt=1 throughout, status 0xA0000003.
- RUN before any key is loaded, and opcode 0x7 → status 0xE0000000 for each; data_rd is never asserted.
- Core that never asserts done, TIMEOUT_CYCLES=16 → status 0xF0000000 after 16 wait cycles; a following RUN succeeds without reloading the key.
- Reset asserted during DRAIN of the 2nd of 3 blocks → outputs 0 next cycle, no ctrl_wr; a RUN afterward returns 0xE0000000.
